approx_mul_sched: RTL

Two-requester scheduler and pipeline controller for the shared 16x16 approximate multiplier with error recovery. Arbitrates round-robin between two operand streams and registers the winning operands into the multiplier core. It captures the core's approximate product and its 12-bit error-recovery vector (product weights 2^31..2^20), applies the correction when the requester asks for it, and returns a tagged 32-bit result over a valid/ready interface with backpressure.

---
 rtl/approx_mul_pkg.sv | 16 +
 rtl/approx_mul_sched_rr_arb2.sv | 32 +++
 rtl/approx_mul_sched.sv | 96 +++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// Shared widths and request record for the approximate-multiplier scheduler.
package approx_mul_pkg;

  localparam int unsigned OP_W    = 16;
  localparam int unsigned PROD_W  = 32;
  localparam int unsigned ERR_W   = 12;
  localparam int unsigned ERR_LSB = 20;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            rec;
    logic            tag;
  } req_t;

endpackage

// File: rtl/approx_mul_sched_rr_arb2.sv
// Two-way round-robin arbiter; grants only while enabled and out of reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = '0;
    if (enable && rst_n) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  // A grant is only issued to a valid requester, so any grant is a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (|grant)
      last <= grant[1];
  end

endmodule

// File: rtl/approx_mul_sched.sv
// Scheduler and two-stage pipeline controller for the shared approximate multiplier.
module approx_mul_sched
  import approx_mul_pkg::*;
#(
  parameter int unsigned TAG_W = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic              req0_rec,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  input  logic              req1_rec,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  input  logic [ERR_W-1:0]  mul_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  rec_count
);

  logic              v1, v2;
  req_t              s1, sel;
  logic [1:0]        grant;
  logic              adv1, adv2;
  logic [PROD_W-1:0] corrected;

  assign adv2 = !v2 || out_ready;
  assign adv1 = !v1 || adv2;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .enable (adv1),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel = '{a: req0_a, b: req0_b, rec: req0_rec, tag: 1'b0};
    if (grant[1])
      sel = '{a: req1_a, b: req1_b, rec: req1_rec, tag: 1'b1};
  end

  // Recovery vector carries product weights 2^31..2^20; carry out of bit 31 is dropped.
  assign corrected = mul_p + {mul_err, {ERR_LSB{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= |grant;
      if (|grant)
        s1 <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data <= s1.rec ? corrected : mul_p;
        out_tag  <= TAG_W'(s1.tag);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rec_count <= '0;
    else if (v1 && adv2 && s1.rec && (mul_err != '0) && (rec_count != '1))
      rec_count <= rec_count + CNT_W'(1);
  end

  assign mul_a     = s1.a;
  assign mul_b     = s1.b;
  assign out_valid = v2;

endmodule
